// File: rtl/inst_fetch_ctrl_if.sv
// Decode-side handshake of the fetch controller: head instruction, its PC, valid/ready.
interface inst_fetch_ctrl_if #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 32
);
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_inst;
    logic [AW-1:0] out_pc;

    modport master (output out_valid, output out_inst, output out_pc, input out_ready);
    modport slave  (input out_valid, input out_inst, input out_pc, output out_ready);
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, folds unconditional jumps, buffers
// fetched words in a 2-entry queue and flushes on execute redirects.
module inst_fetch_ctrl #(
    parameter int unsigned   AW       = 6,
    parameter int unsigned   DW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [5:0]    JMP_OP   = 6'b010010
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    output logic [AW-1:0]        rom_a,
    input  logic [DW-1:0]        rom_inst,
    input  logic                 redirect_valid,
    input  logic [AW-1:0]        redirect_pc,
    output logic                 busy,
    inst_fetch_ctrl_if.master    dec
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [DW-1:0] inst;
        logic [AW-1:0] pc;
    } entry_t;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [1:0]    count_q, count_d;
    logic          valid_q, valid_d;
    entry_t        ent_q [2];
    entry_t        ent_d [2];

    logic pop;
    logic push_ok;
    logic fetch;
    logic is_jmp;

    // Next state, PC and queue; entry 0 is always the head, unused entries held at zero.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        ent_d[0] = ent_q[0];
        ent_d[1] = ent_q[1];

        pop     = valid_q & dec.out_ready;
        push_ok = (state_q == ST_RUN) && ((count_q != 2'd2) || pop);
        fetch   = push_ok && !stop && !redirect_valid;
        is_jmp  = (rom_inst[DW-1 -: 6] == JMP_OP);

        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = ST_RUN;
        end

        if (redirect_valid) begin
            count_d  = 2'd0;
            ent_d[0] = '0;
            ent_d[1] = '0;
            pc_d     = redirect_pc;
        end else begin
            if (pop) begin
                ent_d[0] = ent_q[1];
                ent_d[1] = '0;
                count_d  = count_q - 2'd1;
            end
            if (fetch) begin
                if (is_jmp) begin
                    pc_d = rom_inst[AW-1:0];
                end else begin
                    if (count_d == 2'd0) begin
                        ent_d[0] = '{inst: rom_inst, pc: pc_q};
                    end else begin
                        ent_d[1] = '{inst: rom_inst, pc: pc_q};
                    end
                    count_d = count_d + 2'd1;
                    pc_d    = pc_q + AW'(1);
                end
            end
        end

        valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            count_q  <= 2'd0;
            valid_q  <= 1'b0;
            ent_q[0] <= '0;
            ent_q[1] <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ent_q[0] <= ent_d[0];
            ent_q[1] <= ent_d[1];
        end
    end

    assign rom_a         = pc_q;
    assign busy          = (state_q == ST_RUN);
    assign dec.out_valid = valid_q;
    assign dec.out_inst  = ent_q[0].inst;
    assign dec.out_pc    = ent_q[0].pc;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed cycle vectors over a fixed program, then a
// randomized run scored against a program-order model of the instruction stream.
module tb_inst_fetch_ctrl;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;
    localparam logic [5:0]  JOP = 6'b010010;

    logic          clk = 1'b0;
    logic          rst, start, stop, redirect_valid;
    logic [AW-1:0] redirect_pc, rom_a;
    logic [DW-1:0] rom_inst;
    logic          busy;
    logic [DW-1:0] rom_img [64];

    inst_fetch_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    inst_fetch_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .rom_a          (rom_a),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .dec            (bus.master)
    );

    always #5 clk = ~clk;
    assign rom_inst = rom_img[rom_a];

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        logic       rst, start, stop, rdy, rv;
        logic [5:0] rpc;
        logic       ev;
        logic [5:0] epc, ea;
        logic       eb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, s, p, rdy, rv, input logic [5:0] rpc,
                                input logic ev, input logic [5:0] epc, ea, input logic eb);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    // Follow jumps from p to the next word that decode should actually see.
    function automatic void walk(input logic [5:0] p, output logic [5:0] fp, output logic [31:0] fi);
        logic [5:0] q;
        logic [31:0] w;
        q = p;
        for (int n = 0; n < 64; n++) begin
            w = rom_img[q];
            if (w[31:26] == JOP) q = w[5:0];
            else break;
        end
        fp = q;
        fi = rom_img[q];
    endfunction

    task automatic drive(input logic r, s, p, rdy, rv, input logic [5:0] rpc);
        rst = r; start = s; stop = p; bus.out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  model_pc, fp, rpc;
        logic [31:0] fi, w, exp_inst;
        logic        rdy, rv, s, p;
        logic        jmp [64];
        int          xfers, stall, max_stall;

        // Directed program: jump at 0x0B -> 0x0E, jump-to-self at 0x20.
        for (int i = 0; i < 64; i++) rom_img[i] = 32'h0400_0000 | 32'(i);
        rom_img[6'h01] = 32'h0010_0443;
        rom_img[6'h09] = 32'h1400_1c89;
        rom_img[6'h0B] = 32'h4800_000E;
        rom_img[6'h20] = 32'h4800_0020;
        rom_img[6'h3F] = 32'h0000_0000;

        drive(1, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset.valid", 32'(bus.out_valid), 0);
        check("reset.rom_a", 32'(rom_a), 0);
        check("reset.busy",  32'(busy), 0);
        check("reset.inst",  bus.out_inst, 0);
        check("reset.pc",    32'(bus.out_pc), 0);

        // Start, stream to the jump, bubble, resume at 0x0E.
        vecs.push_back(mk(0,1,0,1,0,0,  0,0,6'h00,1));
        for (int k = 1; k <= 11; k++) vecs.push_back(mk(0,0,0,1,0,0, 1,6'(k-1),6'(k),1));
        vecs.push_back(mk(0,0,0,1,0,0,  0,0,6'h0E,1));
        vecs.push_back(mk(0,0,0,1,0,0,  1,6'h0E,6'h0F,1));
        // Stop with one entry queued, drain while idle.
        vecs.push_back(mk(0,0,1,0,0,0,  1,6'h0E,6'h0F,0));
        vecs.push_back(mk(0,0,0,1,0,0,  0,0,6'h0F,0));
        // Backpressure fills the queue, then redirect to 0x09 while full.
        vecs.push_back(mk(0,1,0,0,0,0,  0,0,6'h0F,1));
        vecs.push_back(mk(0,0,0,0,0,0,  1,6'h0F,6'h10,1));
        vecs.push_back(mk(0,0,0,0,0,0,  1,6'h0F,6'h11,1));
        vecs.push_back(mk(0,0,0,0,0,0,  1,6'h0F,6'h11,1));
        vecs.push_back(mk(0,0,0,0,1,6'h09, 0,0,6'h09,1));
        vecs.push_back(mk(0,0,0,0,0,0,  1,6'h09,6'h0A,1));
        vecs.push_back(mk(0,0,0,1,0,0,  1,6'h0A,6'h0B,1));
        // PC wrap through 0x3F.
        vecs.push_back(mk(0,0,0,1,1,6'h3F, 0,0,6'h3F,1));
        vecs.push_back(mk(0,0,0,0,0,0,  1,6'h3F,6'h00,1));
        vecs.push_back(mk(0,0,0,1,0,0,  1,6'h00,6'h01,1));
        vecs.push_back(mk(0,0,0,0,0,0,  1,6'h00,6'h02,1));
        // Reset with full queue, redirect and start all high.
        vecs.push_back(mk(1,1,0,0,1,6'h20, 0,0,6'h00,0));
        vecs.push_back(mk(0,1,0,1,0,0,  0,0,6'h00,1));
        for (int k = 0; k <= 4; k++) vecs.push_back(mk(0,0,0,1,0,0, 1,6'(k),6'(k+1),1));
        // Stop at pc 5, idle, restart resumes at 5.
        vecs.push_back(mk(0,0,1,1,0,0,  0,0,6'h05,0));
        vecs.push_back(mk(0,0,0,1,0,0,  0,0,6'h05,0));
        vecs.push_back(mk(0,1,0,1,0,0,  0,0,6'h05,1));
        vecs.push_back(mk(0,0,0,1,0,0,  1,6'h05,6'h06,1));
        // Jump-to-self holds the PC with nothing pushed until redirected away.
        vecs.push_back(mk(0,0,0,1,1,6'h20, 0,0,6'h20,1));
        vecs.push_back(mk(0,0,0,1,0,0,  0,0,6'h20,1));
        vecs.push_back(mk(0,0,0,1,0,0,  0,0,6'h20,1));
        vecs.push_back(mk(0,0,0,1,1,6'h30, 0,0,6'h30,1));
        vecs.push_back(mk(0,0,0,1,0,0,  1,6'h30,6'h31,1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
            @(posedge clk);
            #1;
            exp_inst = vecs[i].ev ? rom_img[vecs[i].epc] : 32'h0;
            check($sformatf("v%0d.valid", i), 32'(bus.out_valid), 32'(vecs[i].ev));
            check($sformatf("v%0d.pc", i),    32'(bus.out_pc), vecs[i].ev ? 32'(vecs[i].epc) : 32'h0);
            check($sformatf("v%0d.inst", i),  bus.out_inst, exp_inst);
            check($sformatf("v%0d.rom_a", i), 32'(rom_a), 32'(vecs[i].ea));
            check($sformatf("v%0d.busy", i),  32'(busy), 32'(vecs[i].eb));
        end

        // Random program: jump targets always land on non-jump words.
        for (int i = 0; i < 64; i++) jmp[i] = (i != 0) && ($urandom_range(0, 6) == 0);
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            if (w[31:26] == JOP) w[31] = ~w[31];
            rom_img[i] = w;
        end
        for (int i = 0; i < 64; i++) begin
            if (jmp[i]) begin
                int t;
                t = $urandom_range(0, 63);
                while (jmp[t]) t = (t + 1) % 64;
                w = $urandom;
                rom_img[i] = {JOP, w[19:0], 6'(t)};
            end
        end

        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        model_pc = 6'h00;
        xfers = 0; stall = 0; max_stall = 0;

        for (int c = 0; c < 4000; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = 6'($urandom_range(0, 63));
            p   = ($urandom_range(0, 39) == 0);
            s   = !p && ((c == 0) || ($urandom_range(0, 9) == 0));
            drive(0, s, p, rdy, rv, rpc);
            #1;
            if (bus.out_valid && rdy) begin
                walk(model_pc, fp, fi);
                check("rand.pc",   32'(bus.out_pc), 32'(fp));
                check("rand.inst", bus.out_inst, fi);
                model_pc = fp + 6'd1;
                xfers++;
            end else if (!bus.out_valid && (c % 16 == 0)) begin
                check("rand.empty_inst", bus.out_inst, 0);
            end
            if (rv) model_pc = rpc;
            if (rv) stall = 0;
            else if (busy && !bus.out_valid) stall++;
            else stall = 0;
            if (stall > max_stall) max_stall = stall;
            @(negedge clk);
        end

        check("rand.max_stall_le3", 32'(max_stall <= 3), 1);
        check("rand.throughput",    32'(xfers > 800), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
